// File: rtl/yuv_pixel_sched.sv
// yuv_pixel_sched: per-pixel scheduler wrapped around an external Thumb core that
// computes luma. For each accepted RGB pixel the block:
//   1. writes R, G and B into data memory words 0, 1 and 2;
//   2. holds the core in reset for RST_CYCLES cycles;
//   3. releases the core until it halts or RUN_CYCLES cycles pass;
//   4. reads the core's Y result back from word Y_ADDR, saturating it to 8 bits;
//   5. offers the result on a valid/ready output port.
// Only one pixel is in flight at a time.
//
// Ports
//   clk          clock; all state changes on its rising edge
//   reset        synchronous active-high reset
//   in_valid     pixel offered
//   in_ready     pixel accepted on in_valid && in_ready (IDLE only)
//   in_pix       {R, G, B}, 8 bits each
//   core_reset_n active-low core reset; high only while the core runs
//   core_halt    core finished (SWI); honoured only while running
//   mem_we       data-memory write strobe
//   mem_re       data-memory read strobe
//   mem_addr     data-memory word address (0 when idle)
//   mem_wdata    data-memory write data (0 when idle)
//   mem_rdata    data-memory read data, valid the cycle after mem_re
//   out_valid    Y result available
//   out_ready    result consumed on out_valid && out_ready
//   out_y        saturated luma
//   out_timeout  result came from a run that hit RUN_CYCLES without a halt
//   pix_count    results delivered since reset (wraps)
module yuv_pixel_sched #(
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned RUN_CYCLES = 85,
  parameter int unsigned Y_ADDR     = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_pix,
  output logic        core_reset_n,
  input  logic        core_halt,
  output logic        mem_we,
  output logic        mem_re,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_y,
  output logic        out_timeout,
  output logic [31:0] pix_count
);

  // Terminal values of the shared sub-counter in each timed state.
  localparam logic [15:0] LoadLast = 16'd2;
  localparam logic [15:0] RstLast  = 16'(RST_CYCLES - 1);
  localparam logic [15:0] RunLast  = 16'(RUN_CYCLES - 1);
  localparam logic [7:0]  YAddr    = 8'(Y_ADDR);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRst,
    StRun,
    StRead,
    StWaitRd,
    StOut
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [23:0] pix_q, pix_d;
  logic [7:0]  y_q, y_d;
  logic        tmo_q, tmo_d;
  logic [31:0] count_q, count_d;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pix_d   = pix_q;
    y_d     = y_q;
    tmo_d   = tmo_q;
    count_d = count_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          pix_d   = in_pix;
          cnt_d   = '0;
          state_d = StLoad;
        end
      end

      // One colour word per cycle; cnt_q doubles as the word address.
      StLoad: begin
        if (cnt_q == LoadLast) begin
          cnt_d   = '0;
          state_d = StRst;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StRst: begin
        if (cnt_q == RstLast) begin
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      // Halt is checked first so a halt on the final allowed cycle is not a timeout.
      StRun: begin
        cnt_d = cnt_q + 16'd1;
        if (core_halt) begin
          tmo_d   = 1'b0;
          state_d = StRead;
        end else if (cnt_q == RunLast) begin
          tmo_d   = 1'b1;
          state_d = StRead;
        end
      end

      StRead: begin
        state_d = StWaitRd;
      end

      // Any bit above bit 7 set means the value exceeds 255: clamp to full scale.
      StWaitRd: begin
        y_d     = (|mem_rdata[31:8]) ? 8'hFF : mem_rdata[7:0];
        state_d = StOut;
      end

      StOut: begin
        if (out_ready) begin
          count_d = count_q + 32'd1;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode. Memory bus is driven to zero whenever no strobe is active.
  always_comb begin
    in_ready     = 1'b0;
    core_reset_n = 1'b0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    out_valid    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Gated by reset so the port reads 0 for the whole time reset is held.
        in_ready = ~reset;
      end

      StLoad: begin
        mem_we   = 1'b1;
        mem_addr = cnt_q[7:0];
        case (cnt_q[1:0])
          2'd0:    mem_wdata = {24'b0, pix_q[23:16]};
          2'd1:    mem_wdata = {24'b0, pix_q[15:8]};
          2'd2:    mem_wdata = {24'b0, pix_q[7:0]};
          default: mem_wdata = '0;
        endcase
      end

      StRun: begin
        core_reset_n = 1'b1;
      end

      StRead: begin
        mem_re   = 1'b1;
        mem_addr = YAddr;
      end

      StOut: begin
        out_valid = 1'b1;
      end

      default: begin
      end
    endcase
  end

  assign out_y       = y_q;
  assign out_timeout = tmo_q;
  assign pix_count   = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pix_q   <= '0;
      y_q     <= '0;
      tmo_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pix_q   <= pix_d;
      y_q     <= y_d;
      tmo_q   <= tmo_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_yuv_pixel_sched.sv
// Directed bench for yuv_pixel_sched with a behavioural data memory and core model.
// The core model stores core_result at word 6 on its first run cycle and, when
// halt_en is set, raises core_halt on run cycle number halt_at.
module tb_yuv_pixel_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_pix = '0;
  logic        core_reset_n;
  logic        core_halt;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_y;
  logic        out_timeout;
  logic [31:0] pix_count;

  always #5 clk = ~clk;

  yuv_pixel_sched dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pix       (in_pix),
    .core_reset_n (core_reset_n),
    .core_halt    (core_halt),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_y        (out_y),
    .out_timeout  (out_timeout),
    .pix_count    (pix_count)
  );

  // Memory, core model and bus-protocol monitor.
  logic [31:0] mem [256];
  logic [31:0] core_result = '0;
  bit          halt_en = 1'b0;
  int          halt_at = 0;
  int          run_cnt = 0;
  int          last_run = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          viol = 0;

  assign core_halt = halt_en && core_reset_n && (run_cnt == halt_at - 1);

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_re) begin
      mem_rdata <= mem[mem_addr];
      rd_cnt <= rd_cnt + 1;
    end
    if (core_reset_n) begin
      run_cnt  <= run_cnt + 1;
      last_run <= run_cnt + 1;
      if (run_cnt == 0) mem[6] <= core_result;
    end else begin
      run_cnt <= 0;
    end
    if (!reset && ((mem_we && mem_re) ||
                   (!mem_we && !mem_re && (mem_addr != 8'd0 || mem_wdata != 32'd0)) ||
                   (core_reset_n && (mem_we || mem_re)) ||
                   (in_ready && out_valid))) begin
      viol <= viol + 1;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one pixel, then wait (bounded) for out_valid; lat counts edges after the handshake.
  task automatic run_pixel(input logic [23:0] pix, input logic [31:0] res, input bit hen,
                           input int hat, output int lat);
    core_result = res;
    halt_en     = hen;
    halt_at     = hat;
    in_pix      = pix;
    in_valid    = 1'b1;
    check("in_ready_idle", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 300) begin
      tick();
      lat++;
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int seen;

    // Reset state, observed while reset is still held.
    tick();
    tick();
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_core_reset_n", {31'b0, core_reset_n}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_re", {31'b0, mem_re}, 32'd0);
    check("rst_mem_addr", {24'b0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_y", {24'b0, out_y}, 32'd0);
    check("rst_out_timeout", {31'b0, out_timeout}, 32'd0);
    check("rst_pix_count", pix_count, 32'd0);
    reset = 1'b0;
    tick();
    check("rel_in_ready", {31'b0, in_ready}, 32'd1);

    // Halt after 40 run cycles: latency 3 + 2 + 40 + 2.
    run_pixel(24'h935874, 32'h5C, 1'b1, 40, lat);
    check("a_latency", lat, 32'd47);
    check("a_out_y", {24'b0, out_y}, 32'h5C);
    check("a_timeout", {31'b0, out_timeout}, 32'd0);
    check("a_run_len", last_run, 32'd40);
    check("a_mem0", mem[0], 32'h93);
    check("a_mem1", mem[1], 32'h58);
    check("a_mem2", mem[2], 32'h74);
    check("a_core_off", {31'b0, core_reset_n}, 32'd0);
    accept();
    check("a_out_valid_drop", {31'b0, out_valid}, 32'd0);
    check("a_pix_count", pix_count, 32'd1);

    // No halt: timeout after exactly 85 run cycles.
    run_pixel(24'h102030, 32'h37, 1'b0, 0, lat);
    check("t_latency", lat, 32'd92);
    check("t_run_len", last_run, 32'd85);
    check("t_timeout", {31'b0, out_timeout}, 32'd1);
    check("t_out_y", {24'b0, out_y}, 32'h37);
    check("t_mem0", mem[0], 32'h10);
    accept();
    check("t_pix_count", pix_count, 32'd2);

    // Result above 255 saturates; consumer stalls 10 cycles with a new pixel waiting.
    run_pixel(24'hAABBCC, 32'h12C, 1'b1, 10, lat);
    check("s_latency", lat, 32'd17);
    check("s_timeout", {31'b0, out_timeout}, 32'd0);
    in_pix   = 24'h777777;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("s_stall_valid", {31'b0, out_valid}, 32'd1);
      check("s_stall_y", {24'b0, out_y}, 32'hFF);
      check("s_stall_in_ready", {31'b0, in_ready}, 32'd0);
      tick();
    end
    check("s_stall_count", pix_count, 32'd2);
    accept();
    check("s_after_in_ready", {31'b0, in_ready}, 32'd1);
    check("s_after_out_valid", {31'b0, out_valid}, 32'd0);
    check("s_pix_count", pix_count, 32'd3);
    in_valid = 1'b0;
    tick();

    // Halt on run cycle 85, the same cycle the timeout would fire: halt wins.
    run_pixel(24'h0F0F0F, 32'h81, 1'b1, 85, lat);
    check("h_latency", lat, 32'd92);
    check("h_run_len", last_run, 32'd85);
    check("h_timeout", {31'b0, out_timeout}, 32'd0);
    check("h_out_y", {24'b0, out_y}, 32'h81);
    accept();
    check("h_pix_count", pix_count, 32'd4);

    // Reset pulsed while the core runs aborts the pixel.
    core_result = 32'h99;
    halt_en     = 1'b0;
    in_pix      = 24'h445566;
    in_valid    = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("r_in_run", {31'b0, core_reset_n}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("r_core_reset_n", {31'b0, core_reset_n}, 32'd0);
    check("r_out_valid", {31'b0, out_valid}, 32'd0);
    check("r_mem_we", {31'b0, mem_we}, 32'd0);
    check("r_mem_re", {31'b0, mem_re}, 32'd0);
    check("r_out_y", {24'b0, out_y}, 32'd0);
    check("r_out_timeout", {31'b0, out_timeout}, 32'd0);
    check("r_pix_count", pix_count, 32'd0);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid === 1'b1) seen++;
      tick();
    end
    check("r_no_result", seen, 32'd0);
    check("r_idle_ready", {31'b0, in_ready}, 32'd1);

    // Recovery after the abort.
    run_pixel(24'h010203, 32'h42, 1'b1, 3, lat);
    check("f_latency", lat, 32'd10);
    check("f_out_y", {24'b0, out_y}, 32'h42);
    check("f_mem1", mem[1], 32'h02);
    accept();
    check("f_pix_count", pix_count, 32'd1);

    // Bus totals: six pixels loaded, five read back; no protocol violations.
    check("bus_writes", wr_cnt, 32'd18);
    check("bus_reads", rd_cnt, 32'd5);
    check("bus_violations", viol, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/yuv_pixel_sched.md
YUV_PIXEL_SCHED -- requirements
Module: yuv_pixel_sched

Interface
REQ-001 Parameter RST_CYCLES, default 2: cycles core_reset_n is held low before each pixel run.
REQ-002 Parameter RUN_CYCLES, default 85: maximum cycles the core may run per pixel before a timeout is declared.
REQ-003 Parameter Y_ADDR, default 6: data-memory word address holding the core's Y result.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port in_valid, input, 1: pixel offered.
REQ-007 Port in_ready, output, 1: the block accepts a pixel on a cycle with in_valid && in_ready.
REQ-008 Port in_pix, input, 24: pixel, with [23:16]=R, [15:8]=G, [7:0]=B.
REQ-009 Port core_reset_n, output, 1: active-low reset to the Thumb core.
REQ-010 Port core_halt, input, 1: asserted by the core on SWI completion.
REQ-011 Port mem_we, output, 1: data-memory write strobe.
REQ-012 Port mem_re, output, 1: data-memory read strobe.
REQ-013 Port mem_addr, output, 8: data-memory word address.
REQ-014 Port mem_wdata, output, 32: data-memory write data.
REQ-015 Port mem_rdata, input, 32: data-memory read data, valid the cycle after mem_re.
REQ-016 Port out_valid, output, 1: Y result available.
REQ-017 Port out_ready, input, 1: the consumer accepts the result on a cycle with out_valid && out_ready.
REQ-018 Port out_y, output, 8: saturated luma.
REQ-019 Port out_timeout, output, 1: the current result came from a timed-out run.
REQ-020 Port pix_count, output, 32: number of results delivered since reset.

Function
REQ-021 The FSM SHALL have the states IDLE, LOAD, RST, RUN, READ, WAIT_RD and OUT.
REQ-022 IDLE: in_ready=1; on handshake, latch in_pix, clear the sub-counter, go to LOAD.
REQ-023 LOAD: exactly 3 cycles, writing address 0 = {24'b0,R}, then 1 = {24'b0,G}, then 2 = {24'b0,B}, one word per cycle with mem_we=1; then go to RST.
REQ-024 RST: core_reset_n=0 for exactly RST_CYCLES cycles, then go to RUN.
REQ-025 core_reset_n SHALL be 1 only in RUN and 0 in every other state, so memory access by the block never overlaps core execution.
REQ-026 RUN: the counter increments each cycle. core_halt=1 goes to READ with timeout flag 0. Otherwise, reaching RUN_CYCLES goes to READ with timeout flag 1.
REQ-027 core_halt and the timeout occurring on the same cycle SHALL resolve as halt (flag 0).
REQ-028 READ: one cycle with mem_re=1 and mem_addr=Y_ADDR; next state WAIT_RD.
REQ-029 WAIT_RD: capture mem_rdata, set out_y = (mem_rdata > 255) ? 8'hFF : mem_rdata[7:0], and go to OUT.
REQ-030 OUT: out_valid=1, with out_y and out_timeout stable until the handshake; on handshake increment pix_count (wraps 2^32-1 -> 0) and go to IDLE.
REQ-031 in_ready SHALL be 0 in every state except IDLE; there is no pixel overlap (one pixel in flight).
REQ-032 core_halt SHALL be ignored outside RUN.
REQ-033 mem_we and mem_re SHALL never both be 1; mem_addr and mem_wdata are 0 when no strobe is active.
REQ-034 Per-pixel latency from the in handshake to out_valid SHALL be 3 + RST_CYCLES + run cycles + 2 cycles.
REQ-035 RST_CYCLES >= 1 and RUN_CYCLES >= 1 SHALL be assumed legal; RUN_CYCLES fits a 16-bit counter.

Reset
REQ-036 While reset=1, at the next clk edge: state=IDLE, in_ready=0 during reset then 1 the cycle after release, core_reset_n=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, out_valid=0, out_y=0, out_timeout=0, pix_count=0.
REQ-037 Reset asserted in any state SHALL abort the pixel in flight with no partial result emitted and no pix_count change.

Verification
REQ-038 in_pix=0x93_58_74; the core model writes 0x5C to address 6 and raises core_halt after 40 cycles -> writes 0x93/0x58/0x74 to addresses 0/1/2; out_y=0x5C, out_timeout=0, pix_count=1.
REQ-039 core_halt is never raised, RUN_CYCLES=85 -> exactly 85 RUN cycles; out_timeout=1; out_y equals the address-6 contents.
REQ-040 The core model stores 0x12C at address 6 -> out_y=0xFF (saturated).
REQ-041 out_ready held low 10 cycles -> out_valid/out_y stable throughout; in_ready=0; a second in_valid is not accepted until after the handshake.
REQ-042 reset pulsed in RUN -> next cycle all outputs at reset values, core_reset_n=0, no out_valid, pix_count unchanged at 0.
REQ-043 core_halt and the timeout on the same cycle -> out_timeout=0.
